// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline stage between EX and WB. Accepts one EX record
// per handshake, waits for the data-SRAM load response, aligns and extends
// sub-word loads, then holds the write-back record until WB takes it.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard the held entry and drop any pending response
//   ex_valid/ex_*       EX record in; mem_allowin is the accept ready
//   dsram_rvalid/rdata  load response from the data SRAM
//   wb_allowin          WB ready; mem_to_wb_valid/bus carry {pc,we,waddr,wdata}
//   mem_to_id_bus       forwarding {fwd_we,waddr,wdata}; stallreq_mem in WAIT
//   err_misalign        one-cycle pulse, aligned with the faulting HOLD record
//   err_timeout         one-cycle pulse, aligned with the timed-out HOLD record
module mem_stage_lsu #(
    parameter int PC_W    = 32,
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int LAT_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          ex_valid,
    output logic                          mem_allowin,
    input  logic [PC_W-1:0]               ex_pc,
    input  logic                          ex_rf_we,
    input  logic [RF_AW-1:0]              ex_rf_waddr,
    input  logic [DATA_W-1:0]             ex_result,
    input  logic [2:0]                    ex_ld_type,
    input  logic                          dsram_rvalid,
    input  logic [DATA_W-1:0]             dsram_rdata,
    input  logic                          wb_allowin,
    output logic                          mem_to_wb_valid,
    output logic [PC_W+RF_AW+DATA_W:0]    mem_to_wb_bus,
    output logic [RF_AW+DATA_W:0]         mem_to_id_bus,
    output logic                          stallreq_mem,
    output logic                          err_misalign,
    output logic                          err_timeout
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MAX - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;
    localparam logic [2:0] LD_WU   = 3'd6;
    localparam logic [2:0] LD_D    = 3'd7;

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              rf_we_q, rf_we_d;
    logic [RF_AW-1:0]  rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;

    logic              accept;
    logic [2:0]        ld_norm;
    logic [2:0]        off3;
    logic              misalign;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] ld_data;

    assign mem_allowin = (state_q == S_IDLE) ||
                         (state_q == S_HOLD && wb_allowin);
    // flush blocks acceptance even though mem_allowin may be high
    assign accept = ex_valid && mem_allowin && !flush;

    // On a 32-bit datapath LWU and LD degrade to LW
    always_comb begin
        ld_norm = ex_ld_type;
        if (DATA_W == 32 && (ex_ld_type == LD_WU || ex_ld_type == LD_D))
            ld_norm = LD_W;
    end

    assign off3 = 3'(ex_result[OFF_W-1:0]);

    always_comb begin
        misalign = 1'b0;
        unique case (ld_norm)
            LD_H, LD_HU: misalign = off3[0];
            LD_W, LD_WU: misalign = |off3[1:0];
            LD_D:        misalign = |off3;
            default:     misalign = 1'b0;
        endcase
    end

    // Aligned loads only reach here, so a byte shift selects any lane
    assign sh = dsram_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_data = '0;
        unique case (ld_type_q)
            LD_B: begin
                ld_data = {DATA_W{sh[7]}};
                ld_data[7:0] = sh[7:0];
            end
            LD_BU: ld_data[7:0] = sh[7:0];
            LD_H: begin
                ld_data = {DATA_W{sh[15]}};
                ld_data[15:0] = sh[15:0];
            end
            LD_HU: ld_data[15:0] = sh[15:0];
            LD_W: begin
                ld_data = {DATA_W{sh[31]}};
                ld_data[31:0] = sh[31:0];
            end
            LD_WU: ld_data[31:0] = sh[31:0];
            default: ld_data = sh;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rf_we_d    = rf_we_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        ld_type_d  = ld_type_q;
        off_d      = off_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        drop_cnt_d = drop_cnt_q;
        err_mis_d  = 1'b0;
        err_to_d   = 1'b0;

        // A dropped response is consumed by the next rvalid or expires
        if (drop_q) begin
            if (dsram_rvalid || drop_cnt_q == CNT_LAST)
                drop_d = 1'b0;
            else
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            state_d = S_IDLE;
            if (state_q == S_WAIT) begin
                // rvalid in this very cycle already answers our own load
                // unless it belongs to an earlier dropped one
                drop_d     = !(dsram_rvalid && !drop_q);
                drop_cnt_d = '0;
            end
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (dsram_rvalid && !drop_q) begin
                        rf_wdata_d = ld_data;
                        state_d    = S_HOLD;
                    end else if (cnt_q == CNT_LAST) begin
                        err_to_d   = 1'b1;
                        rf_we_d    = 1'b0;
                        rf_wdata_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_HOLD: if (wb_allowin) state_d = S_IDLE;
                default: ;
            endcase

            if (accept) begin
                pc_d       = ex_pc;
                rf_waddr_d = ex_rf_waddr;
                ld_type_d  = ld_norm;
                off_d      = ex_result[OFF_W-1:0];
                cnt_d      = '0;
                if (ld_norm == LD_NONE) begin
                    rf_we_d    = ex_rf_we;
                    rf_wdata_d = ex_result;
                    state_d    = S_HOLD;
                end else if (misalign) begin
                    err_mis_d  = 1'b1;
                    rf_we_d    = 1'b0;
                    rf_wdata_d = '0;
                    state_d    = S_HOLD;
                end else begin
                    rf_we_d    = ex_rf_we;
                    rf_wdata_d = '0;
                    state_d    = S_WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            ld_type_q  <= LD_NONE;
            off_q      <= '0;
            cnt_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            ld_type_q  <= ld_type_d;
            off_q      <= off_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
        end
    end

    assign mem_to_wb_valid = (state_q == S_HOLD);
    assign mem_to_wb_bus   = {pc_q, rf_we_q, rf_waddr_q, rf_wdata_q};
    assign mem_to_id_bus   = {rf_we_q && state_q == S_HOLD,
                              rf_waddr_q, rf_wdata_q};
    assign stallreq_mem    = (state_q == S_WAIT);
    assign err_misalign    = err_mis_q;
    assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: scoreboard bench for mem_stage_lsu, 32- and 64-bit
// instances; expected WB records are queued at drive time.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_rf_we, dsram_rvalid, wb_allowin;
    logic [31:0] ex_pc, ex_result, dsram_rdata;
    logic [4:0]  ex_rf_waddr;
    logic [2:0]  ex_ld_type;
    logic        allowin, wb_valid, stall, err_mis, err_to;
    logic [69:0] wb_bus;
    logic [37:0] id_bus;

    logic        ex_valid64, rvalid64;
    logic [63:0] result64, rdata64;
    logic        allowin64, valid64, stall64, mis64, to64;
    logic [101:0] wb_bus64;
    logic [69:0]  id_bus64;

    logic [69:0]  q32[$];
    logic [101:0] q64[$];
    logic [69:0]  exp32;
    logic [101:0] exp64;

    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_stage_lsu u32 (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid),
        .mem_allowin(allowin), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result),
        .ex_ld_type(ex_ld_type), .dsram_rvalid(dsram_rvalid),
        .dsram_rdata(dsram_rdata), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(wb_valid), .mem_to_wb_bus(wb_bus),
        .mem_to_id_bus(id_bus), .stallreq_mem(stall),
        .err_misalign(err_mis), .err_timeout(err_to)
    );

    mem_stage_lsu #(.DATA_W(64)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid64),
        .mem_allowin(allowin64), .ex_pc(ex_pc), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(result64),
        .ex_ld_type(ex_ld_type), .dsram_rvalid(rvalid64),
        .dsram_rdata(rdata64), .wb_allowin(wb_allowin),
        .mem_to_wb_valid(valid64), .mem_to_wb_bus(wb_bus64),
        .mem_to_id_bus(id_bus64), .stallreq_mem(stall64),
        .err_misalign(mis64), .err_timeout(to64)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rec(input logic [31:0] pc, input logic we,
                             input logic [4:0] wa, input logic [31:0] res,
                             input logic [2:0] lt);
        ex_valid    = 1'b1;
        ex_pc       = pc;
        ex_rf_we    = we;
        ex_rf_waddr = wa;
        ex_result   = res;
        ex_ld_type  = lt;
    endtask

    task automatic test_reset;
        n_assert++;
        if (allowin !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: got allowin=%b valid=%b stall=%b want 1 0 0",
                     allowin, wb_valid, stall);
        end
        n_assert++;
        if (err_mis !== 1'b0 || err_to !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b%b want 00", err_mis, err_to);
        end
        n_assert++;
        if (id_bus !== 38'd0 || wb_bus !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got id=%h wb=%h want 0", id_bus, wb_bus);
        end
        n_assert++;
        if (valid64 !== 1'b0 || allowin64 !== 1'b1 || id_bus64 !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_64: got valid=%b allowin=%b id=%h want 0 1 0",
                     valid64, allowin64, id_bus64);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lb;
        drive_rec(32'h100, 1'b1, 5'd3, 32'h1003, 3'b001);
        q32.push_back({32'h100, 1'b1, 5'd3, 32'hFFFFFF80});
        tick();
        ex_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_assert++;
            if (stall !== 1'b1 || wb_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL lb_stall%0d: got stall=%b valid=%b want 1 0",
                         k, stall, wb_valid);
            end
            if (k == 1) begin
                dsram_rvalid = 1'b1;
                dsram_rdata  = 32'h80FF1234;
            end
            tick();
        end
        dsram_rvalid = 1'b0;
        n_assert++;
        exp32 = q32.pop_front();
        if (wb_valid !== 1'b1 || wb_bus !== exp32 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lb_wb: got valid=%b bus=%h stall=%b want 1 %h 0",
                     wb_valid, wb_bus, stall, exp32);
        end
        n_assert++;
        if (id_bus !== {1'b1, 5'd3, 32'hFFFFFF80}) begin
            n_fail++;
            $display("FAIL lb_fwd: got %h want %h", id_bus,
                     {1'b1, 5'd3, 32'hFFFFFF80});
        end
        tick();
    endtask

    task automatic test_lhu_backpressure;
        wb_allowin = 1'b0;
        drive_rec(32'h104, 1'b1, 5'd4, 32'h1002, 3'b100);
        q32.push_back({32'h104, 1'b1, 5'd4, 32'h00009ABC});
        tick();
        ex_valid     = 1'b0;
        dsram_rvalid = 1'b1;
        dsram_rdata  = 32'h9ABC0000;
        tick();
        dsram_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (wb_valid !== 1'b1 || wb_bus !== q32[0] || allowin !== 1'b0) begin
                n_fail++;
                $display("FAIL lhu_hold%0d: got valid=%b bus=%h allowin=%b want 1 %h 0",
                         k, wb_valid, wb_bus, allowin, q32[0]);
            end
            tick();
        end
        wb_allowin = 1'b1;
        #1;
        n_assert++;
        exp32 = q32.pop_front();
        if (allowin !== 1'b1 || wb_bus !== exp32) begin
            n_fail++;
            $display("FAIL lhu_release: got allowin=%b bus=%h want 1 %h",
                     allowin, wb_bus, exp32);
        end
        tick();
        n_assert++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lhu_idle: got valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        r = $urandom;
        drive_rec(32'h200, 1'b1, 5'd1, r, 3'b000);
        q32.push_back({32'h200, 1'b1, 5'd1, r});
        tick();
        for (int i = 1; i <= 5; i++) begin
            n_assert++;
            exp32 = q32.pop_front();
            if (wb_valid !== 1'b1 || wb_bus !== exp32 || stall !== 1'b0 ||
                id_bus[37] !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d: got valid=%b bus=%h stall=%b fwd=%b want 1 %h 0 1",
                         i, wb_valid, wb_bus, stall, id_bus[37], exp32);
            end
            if (i < 5) begin
                r = $urandom;
                drive_rec(32'h200 + 32'(4 * i), 1'b1, 5'(i + 1), r, 3'b000);
                q32.push_back({32'h200 + 32'(4 * i), 1'b1, 5'(i + 1), r});
            end else begin
                ex_valid = 1'b0;
            end
            tick();
        end
        n_assert++;
        if (wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: got valid=%b want 0", wb_valid);
        end
    endtask

    task automatic test_misalign;
        drive_rec(32'h300, 1'b1, 5'd5, 32'h1001, 3'b011);
        q32.push_back({32'h300, 1'b0, 5'd5, 32'h0});
        tick();
        ex_valid = 1'b0;
        n_assert++;
        exp32 = q32.pop_front();
        if (err_mis !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b1 ||
            wb_bus !== exp32) begin
            n_fail++;
            $display("FAIL misalign: got err=%b stall=%b valid=%b bus=%h want 1 0 1 %h",
                     err_mis, stall, wb_valid, wb_bus, exp32);
        end
        tick();
        n_assert++;
        if (err_mis !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_pulse: got err=%b valid=%b want 0 0",
                     err_mis, wb_valid);
        end
    endtask

    task automatic test_timeout;
        drive_rec(32'h400, 1'b1, 5'd6, 32'h1000, 3'b101);
        q32.push_back({32'h400, 1'b0, 5'd6, 32'h0});
        tick();
        ex_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_assert++;
            if (stall !== 1'b1 || err_to !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait%0d: got stall=%b err=%b want 1 0",
                         k, stall, err_to);
            end
            tick();
        end
        n_assert++;
        exp32 = q32.pop_front();
        if (err_to !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b1 ||
            wb_bus !== exp32) begin
            n_fail++;
            $display("FAIL timeout: got err=%b stall=%b valid=%b bus=%h want 1 0 1 %h",
                     err_to, stall, wb_valid, wb_bus, exp32);
        end
        tick();
        n_assert++;
        if (err_to !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b want 0", err_to);
        end
    endtask

    task automatic test_flush;
        drive_rec(32'h500, 1'b1, 5'd7, 32'h1000, 3'b101);
        tick();
        ex_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_assert++;
        if (stall !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got stall=%b valid=%b want 0 0",
                     stall, wb_valid);
        end
        drive_rec(32'h504, 1'b1, 5'd8, 32'h1004, 3'b101);
        q32.push_back({32'h504, 1'b1, 5'd8, 32'h11223344});
        tick();
        ex_valid     = 1'b0;
        dsram_rvalid = 1'b1;
        dsram_rdata  = 32'hDEADBEEF;
        tick();
        n_assert++;
        if (stall !== 1'b1 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_late: got stall=%b valid=%b want 1 0",
                     stall, wb_valid);
        end
        dsram_rdata = 32'h11223344;
        tick();
        dsram_rvalid = 1'b0;
        n_assert++;
        exp32 = q32.pop_front();
        if (wb_valid !== 1'b1 || wb_bus !== exp32) begin
            n_fail++;
            $display("FAIL flush_next: got valid=%b bus=%h want 1 %h",
                     wb_valid, wb_bus, exp32);
        end
        tick();
        drive_rec(32'h508, 1'b1, 5'd9, 32'h55, 3'b000);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        ex_valid = 1'b0;
        n_assert++;
        if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_block: got valid=%b stall=%b want 0 0",
                     wb_valid, stall);
        end
    endtask

    task automatic test_reset_mid;
        drive_rec(32'h700, 1'b1, 5'd2, 32'h1000, 3'b101);
        tick();
        ex_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_assert++;
        if (stall !== 1'b0 || wb_valid !== 1'b0 || allowin !== 1'b1 ||
            id_bus !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got stall=%b valid=%b allowin=%b id=%h want 0 0 1 0",
                     stall, wb_valid, allowin, id_bus);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ld64;
        ex_valid64 = 1'b1;
        ex_pc = 32'h600; ex_rf_we = 1'b1; ex_rf_waddr = 5'd9;
        ex_ld_type = 3'b111;
        result64 = 64'h2000;
        q64.push_back({32'h600, 1'b1, 5'd9, 64'h8000000000000001});
        tick();
        ex_valid64 = 1'b0;
        n_assert++;
        if (stall64 !== 1'b1) begin
            n_fail++;
            $display("FAIL ld64_stall: got %b want 1", stall64);
        end
        rvalid64 = 1'b1;
        rdata64  = 64'h8000000000000001;
        tick();
        rvalid64 = 1'b0;
        n_assert++;
        exp64 = q64.pop_front();
        if (valid64 !== 1'b1 || wb_bus64 !== exp64) begin
            n_fail++;
            $display("FAIL ld64: got valid=%b bus=%h want 1 %h",
                     valid64, wb_bus64, exp64);
        end
        ex_valid64 = 1'b1;
        ex_pc = 32'h604; ex_rf_waddr = 5'd10;
        ex_ld_type = 3'b101;
        result64 = 64'h2004;
        q64.push_back({32'h604, 1'b1, 5'd10, 64'hFFFFFFFF80000000});
        tick();
        ex_valid64 = 1'b0;
        rvalid64   = 1'b1;
        rdata64    = 64'h80000000_12345678;
        tick();
        rvalid64 = 1'b0;
        n_assert++;
        exp64 = q64.pop_front();
        if (valid64 !== 1'b1 || wb_bus64 !== exp64 || mis64 !== 1'b0 ||
            to64 !== 1'b0) begin
            n_fail++;
            $display("FAIL lw64: got valid=%b bus=%h err=%b%b want 1 %h 00",
                     valid64, wb_bus64, mis64, to64, exp64);
        end
        tick();
        n_assert++;
        if (valid64 !== 1'b0) begin
            n_fail++;
            $display("FAIL ld64_idle: got %b want 0", valid64);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_rf_we = 1'b0;
        dsram_rvalid = 1'b0; wb_allowin = 1'b1; ex_pc = '0;
        ex_result = '0; dsram_rdata = '0; ex_rf_waddr = '0;
        ex_ld_type = '0; ex_valid64 = 1'b0; rvalid64 = 1'b0;
        result64 = '0; rdata64 = '0;
        repeat (2) tick();
        test_reset();
        test_lb();
        test_lhu_backpressure();
        test_back_to_back();
        test_misalign();
        test_timeout();
        test_flush();
        test_reset_mid();
        test_ld64();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
